// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary hi/lo gate drive with dead-time insertion
// Re-times the raw PWM level and counts pulses too short to survive the dead time.
module pwm_deadtime_gen #(
    parameter int DT_W        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SCNT_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              pts_i,
    input  logic [DT_W-1:0]   dead_rise_i,
    input  logic [DT_W-1:0]   dead_fall_i,
    input  logic              scnt_clr_i,
    output logic              pwm_hi_o,
    output logic              pwm_lo_o,
    output logic              oe_o,
    output logic              dead_o,
    output logic [SCNT_W-1:0] scnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DT_RISE = 3'd1,
        HI_ON   = 3'd2,
        DT_FALL = 3'd3,
        LO_ON   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DT_W-1:0]        cnt_q, cnt_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic                   swallow;
    logic                   pts_s;
    logic                   hi_q, lo_q, oe_q, dead_q;

    assign pts_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swallow = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pts_s) begin
                        state_d = DT_RISE;
                        cnt_d   = dead_rise_i;
                    end else begin
                        state_d = DT_FALL;
                        cnt_d   = dead_fall_i;
                    end
                end
                LO_ON: begin
                    if (pts_s) begin
                        state_d = DT_RISE;
                        cnt_d   = dead_rise_i;
                    end
                end
                HI_ON: begin
                    if (!pts_s) begin
                        state_d = DT_FALL;
                        cnt_d   = dead_fall_i;
                    end
                end
                DT_RISE: begin
                    // Level fell back before the high side could turn on.
                    if (!pts_s) begin
                        state_d = LO_ON;
                        swallow = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                DT_FALL: begin
                    if (pts_s) begin
                        state_d = DT_RISE;
                        cnt_d   = dead_rise_i;
                        swallow = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        if (scnt_clr_i) begin
            scnt_d = '0;
        end else if (swallow && (scnt_q != '1)) begin
            scnt_d = scnt_q + SCNT_W'(1);
        end
    end

    // Drives are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            scnt_q  <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            oe_q    <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pts_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            hi_q    <= (state_d == HI_ON);
            lo_q    <= (state_d == LO_ON);
            oe_q    <= (state_d != IDLE);
            dead_q  <= (state_d == DT_RISE) || (state_d == DT_FALL);
        end
    end

    assign pwm_hi_o = hi_q;
    assign pwm_lo_o = lo_q;
    assign oe_o     = oe_q;
    assign dead_o   = dead_q;
    assign scnt_o   = scnt_q;

endmodule
